systolic_feeder: RTL and testbench

Upstream stage of the 4x4 output-stationary systolic multiplier. It buffers the two 4x4 operand matrices A and B written by the host, then streams them into the array's left and top edges with the diagonal skew the array requires: row i of A is delayed i cycles and column j of B is delayed j cycles, with zero padding. It also pulses an accumulator clear before each run and signals completion once the last product has settled in the array.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/skew_lane_sel.sv | 31 +++
 rtl/systolic_feeder.sv | 176 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder.
// Holds the array geometry, the feeder FSM state type and the phase lengths.
package systolic_pkg;

    localparam int DATA_W = 32;   // element width
    localparam int N      = 4;    // array dimension (only 4 is supported)

    localparam int LANE_W = 2;    // bits to name one lane / row / column
    localparam int ADDR_W = 4;    // bits to name one matrix element (row*4 + col)
    localparam int CNT_W  = 3;    // phase counter width, covers 0..FEED_CYCLES-1

    localparam int FEED_CYCLES  = 2 * N - 1;
    localparam int DRAIN_CYCLES = N;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } feed_state_t;

endpackage

// File: rtl/skew_lane_sel.sv
// Combinational skew selector for one edge lane of the array.
// For FEED counter c and lane index l, the lane carries operand index k = c - l
// when 0 <= k < N.  Row mode (A, left edge) addresses A[l][k]; column mode
// (B, top edge) addresses B[k][l].
//   cnt_i      : FEED cycle counter
//   lane_i     : lane index
//   col_mode_i : 0 = row lane of A, 1 = column lane of B
//   idx_o      : element index row*4 + col
//   valid_o    : 1 when the lane carries a real element, 0 for zero padding
module skew_lane_sel
    import systolic_pkg::*;
(
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic              col_mode_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              valid_o
);

    logic [CNT_W-1:0]  k_full;
    logic [LANE_W-1:0] k;

    // Wraps when cnt_i < lane_i; the compare below rejects those cases.
    assign k_full  = cnt_i - {1'b0, lane_i};
    assign k       = k_full[LANE_W-1:0];
    assign valid_o = (cnt_i >= {1'b0, lane_i}) && (k_full < CNT_W'(N));

    // With N = 4, row*4 + col is just the concatenation {row, col}.
    assign idx_o = col_mode_i ? {k, lane_i} : {lane_i, k};

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the 4x4 output-stationary systolic multiplier.
// Buffers matrices A and B written by the host, then on start runs
// CLEAR (1) -> FEED (7) -> DRAIN (4) -> DONE (1), streaming A rows into the
// left edge and B columns into the top edge with a diagonal skew.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   wr_en_i/sel/addr  : host element write (sel 0 = A, 1 = B), honoured in IDLE only
//   wr_data_i         : element value
//   start_i           : begin a run, honoured in IDLE only
//   busy_o            : run in progress, through the DONE cycle
//   arr_clr_o         : accumulator clear pulse (CLEAR cycle)
//   feed_valid_o      : skewed data on left_o / up_o
//   left_o, up_o      : lane i at bits [i*DATA_W +: DATA_W]
//   done_o            : results settled in the array
module systolic_feeder #(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int N      = systolic_pkg::N
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic                wr_sel_i,
    input  logic [3:0]          wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                arr_clr_o,
    output logic                feed_valid_o,
    output logic [N*DATA_W-1:0] left_o,
    output logic [N*DATA_W-1:0] up_o,
    output logic                done_o
);
    import systolic_pkg::*;

    feed_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q [N*N];
    logic [DATA_W-1:0] a_d [N*N];
    logic [DATA_W-1:0] b_q [N*N];
    logic [DATA_W-1:0] b_d [N*N];

    logic              busy_q, busy_d;
    logic              clr_q, clr_d;
    logic              fv_q, fv_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] left_q [N];
    logic [DATA_W-1:0] left_d [N];
    logic [DATA_W-1:0] up_q [N];
    logic [DATA_W-1:0] up_d [N];

    // Next state, counter and buffer contents.
    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            ST_IDLE: begin
                // A write in the start cycle lands before the first FEED
                // value is registered, so the run sees it.
                if (wr_en_i) begin
                    if (wr_sel_i) b_d[wr_addr_i] = wr_data_i;
                    else          a_d[wr_addr_i] = wr_data_i;
                end
                if (start_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                cnt_d   = '0;
            end
            ST_FEED: begin
                if (cnt_q == CNT_W'(FEED_CYCLES - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the *next* state so each output lines up
    // with the state it describes.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        clr_d  = (state_d == ST_CLEAR);
        fv_d   = (state_d == ST_FEED);
        done_d = (state_d == ST_DONE);
    end

    // Buffers only change in IDLE, so a_q / b_q are stable for the whole run.
    for (genvar l = 0; l < N; l++) begin : g_lane
        logic [ADDR_W-1:0] left_idx, up_idx;
        logic              left_ok, up_ok;

        skew_lane_sel u_left_sel (
            .cnt_i      (cnt_d),
            .lane_i     (LANE_W'(l)),
            .col_mode_i (1'b0),
            .idx_o      (left_idx),
            .valid_o    (left_ok)
        );

        skew_lane_sel u_up_sel (
            .cnt_i      (cnt_d),
            .lane_i     (LANE_W'(l)),
            .col_mode_i (1'b1),
            .idx_o      (up_idx),
            .valid_o    (up_ok)
        );

        assign left_d[l] = (fv_d && left_ok) ? a_q[left_idx] : '0;
        assign up_d[l]   = (fv_d && up_ok)   ? b_q[up_idx]   : '0;

        assign left_o[l*DATA_W +: DATA_W] = left_q[l];
        assign up_o[l*DATA_W +: DATA_W]   = up_q[l];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            fv_q    <= 1'b0;
            done_q  <= 1'b0;
            // NOTE: the operand buffers are flop arrays that must read as zero
            // after reset, so they are cleared here rather than left as RAM.
            for (int k = 0; k < N*N; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 0; k < N; k++) begin
                left_q[k] <= '0;
                up_q[k]   <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            clr_q   <= clr_d;
            fv_q    <= fv_d;
            done_q  <= done_d;
            for (int k = 0; k < N*N; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
            for (int k = 0; k < N; k++) begin
                left_q[k] <= left_d[k];
                up_q[k]   <= up_d[k];
            end
        end
    end

    assign busy_o       = busy_q;
    assign arr_clr_o    = clr_q;
    assign feed_valid_o = fv_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus pushes per-cycle expected
// output records computed from the matrix contents; a negedge monitor pops
// and compares them, and expects quiet outputs whenever no record is due.
module tb_systolic_feeder;

    localparam int DW = 32;
    localparam int NN = 4;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             wr_en_i = 1'b0;
    logic             wr_sel_i = 1'b0;
    logic [3:0]       wr_addr_i = '0;
    logic [DW-1:0]    wr_data_i = '0;
    logic             start_i = 1'b0;
    logic             busy_o, arr_clr_o, feed_valid_o, done_o;
    logic [NN*DW-1:0] left_o, up_o;

    systolic_feeder #(.DATA_W(DW), .N(NN)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .wr_en_i      (wr_en_i),
        .wr_sel_i     (wr_sel_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .arr_clr_o    (arr_clr_o),
        .feed_valid_o (feed_valid_o),
        .left_o       (left_o),
        .up_o         (up_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        bit               busy, clr, fv, done;
        logic [NN*DW-1:0] left, up;
    } rec_t;

    rec_t          exp_q[$];
    logic [DW-1:0] ma [16];
    logic [DW-1:0] mb [16];
    int            idle_from = 0;   // first cycle the model considers IDLE
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic check(input string name, input logic [NN*DW-1:0] act,
                         input logic [NN*DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    endtask

    // Expected output for every cycle of a run started at cycle s.
    task automatic push_run(input int s);
        rec_t r;
        for (int t = 1; t <= 13; t++) begin
            r.cyc  = s + t;
            r.busy = 1'b1;
            r.clr  = (t == 1);
            r.fv   = (t >= 2 && t <= 8);
            r.done = (t == 13);
            r.left = '0;
            r.up   = '0;
            if (r.fv) begin
                for (int l = 0; l < NN; l++) begin
                    int k;
                    k = (t - 2) - l;
                    if (k >= 0 && k < NN) begin
                        r.left[l*DW +: DW] = ma[l*NN + k];
                        r.up[l*DW +: DW]   = mb[k*NN + l];
                    end
                end
            end
            exp_q.push_back(r);
        end
    endtask

    // Drive one cycle of inputs and update the reference model.
    task automatic step(input bit we, input bit sel, input logic [3:0] addr,
                        input logic [DW-1:0] data, input bit st, input bit rs);
        wr_en_i = we; wr_sel_i = sel; wr_addr_i = addr; wr_data_i = data;
        start_i = st; rst_i = rs;
        if (rs) begin
            for (int k = 0; k < 16; k++) begin ma[k] = '0; mb[k] = '0; end
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc)
                void'(exp_q.pop_back());
            idle_from = cyc + 1;
        end else begin
            if (we && cyc >= idle_from) begin
                if (sel) mb[addr] = data;
                else     ma[addr] = data;
            end
            if (st && cyc >= idle_from) begin
                push_run(cyc);
                idle_from = cyc + 14;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr(input bit sel, input logic [3:0] addr, input logic [DW-1:0] data);
        step(1'b1, sel, addr, data, 1'b0, 1'b0);
    endtask

    task automatic start_only();
        step(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b0);
    endtask

    // Start, then 13 cycles with random write attempts that must be dropped.
    task automatic run_noisy();
        start_only();
        for (int k = 0; k < 13; k++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), DW'($urandom), 1'b0, 1'b0);
    endtask

    // Monitor: compare against the due record, or expect quiet outputs.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missed_record", 128'(exp_q[0].cyc), 128'(cyc));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                rec_t r;
                r = exp_q.pop_front();
                check("busy", 128'(busy_o), 128'(r.busy));
                check("arr_clr", 128'(arr_clr_o), 128'(r.clr));
                check("feed_valid", 128'(feed_valid_o), 128'(r.fv));
                check("done", 128'(done_o), 128'(r.done));
                check("left", left_o, r.left);
                check("up", up_o, r.up);
            end else begin
                check("idle_ctrl", 128'({busy_o, arr_clr_o, feed_valid_o, done_o}), 128'(0));
                check("idle_data", left_o | up_o, '0);
            end
        end
    end

    initial begin
        for (int k = 0; k < 16; k++) begin ma[k] = '0; mb[k] = '0; end
        step(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b1);
        idle(2);

        // Identity x B, with B written last in the same cycle as start.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                wr(1'b0, 4'(r*4 + c), (r == c) ? 32'd1 : 32'd0);
                if (!(r == 3 && c == 3)) wr(1'b1, 4'(r*4 + c), 32'(r*4 + c + 1));
            end
        step(1'b1, 1'b1, 4'd15, 32'd16, 1'b1, 1'b0);
        idle(14);

        // Skew pattern A[i][k] = 0x10*i + k.
        for (int k = 0; k < 16; k++) wr(1'b0, 4'(k), 32'((k / 4) * 16 + (k % 4)));
        start_only();
        idle(13);

        // Write lockout: write during FEED is dropped, IDLE write lands.
        start_only();
        idle(3);
        wr(1'b0, 4'd0, 32'hDEAD);
        idle(10);
        start_only();
        idle(13);
        wr(1'b0, 4'd0, 32'h55);
        start_only();
        idle(13);

        // Start while busy at S+5: ignored.
        start_only();
        idle(4);
        start_only();
        idle(9);

        // Random contents, noisy runs, back-to-back starts.
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 16; k++) begin
                wr(1'b0, 4'(k), DW'($urandom));
                wr(1'b1, 4'(k), DW'($urandom));
            end
            run_noisy();
            run_noisy();
            idle(1);
        end

        // Reset at S+6 aborts the run; next run streams zeros.
        start_only();
        idle(5);
        step(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b1);
        idle(3);
        start_only();
        idle(13);
        idle(3);

        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
